canvas_ctrl: RTL and testbench
==============================

Name: canvas_ctrl

Overview:
Frame-buffer write controller for the light-pen screen. Sits between the mode FSM (3-bit `state` output), the pen hit detector and the frame-buffer RAM write port. Clears the canvas on every RST entry and returns `rst_ok` to the mode FSM. Serialises pen hits into pixel writes according to the current mode.

Parameters:
ROWS, 8, pixel rows
COLS, 8, pixel columns
ADDR_W, 6, frame-buffer address width; must satisfy 2^ADDR_W >= ROWS*COLS
COLOR_W, 2, pixel colour width; value 0 = pixel off

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
state  input  3  mode from mode FSM; codes are the shared state-header macros RST/SLEEP/LIGHT/DRAW/WRITE/ERASE/COLOR/STOP
pen_valid  input  1  pen hit present
pen_row  input  3  hit row
pen_col  input  3  hit column
pen_ready  output  1  hit accepted when pen_valid & pen_ready
fb_we  output  1  frame-buffer write strobe, one pixel per cycle
fb_addr  output  ADDR_W  pixel address = row*COLS + col
fb_wdata  output  COLOR_W  pixel value
cur_color  output  COLOR_W  active pen colour
rst_ok  output  1  canvas clear complete, to mode FSM
busy  output  1  high in CLEAR, WR1, WR2

Behaviour:
- Async reset values:
  - fb_we=0, fb_addr=0, fb_wdata=0, rst_ok=0, pen_ready=0, cur_color=1.
  - Internal FSM = CLEAR, sweep counter = 0.
- FSM states: CLEAR, DONE, IDLE, WR1, WR2. All outputs are registered.
- CLEAR:
  - One write per cycle: fb_we=1, fb_addr=counter, fb_wdata=0, counter 0..ROWS*COLS-1.
  - pen_ready=0, rst_ok=0.
  - The first write appears on the first clock edge after reset deassertion.
  - After the last address, go to DONE; the next cycle has fb_we=0.
  - cur_color is reloaded to 1 on CLEAR entry.
- DONE:
  - rst_ok=1, fb_we=0, pen_ready=0.
  - Stay while state==RST. Go to IDLE when state!=RST; rst_ok drops in the same transition.
- IDLE:
  - If state==RST, go to CLEAR with counter=0. This check has priority over a pen hit in the same cycle; that hit is not accepted.
  - Otherwise pen_ready=1. On handshake, latch row, col and the mode sampled that cycle. A later mode change does not affect the latched operation.
  - Out-of-range hit (row>=ROWS or col>=COLS): accepted and dropped, stay IDLE, no write.
  - DRAW: go to WR1 with data=cur_color.
  - ERASE: go to WR1 with data=0.
  - WRITE: go to WR1 with data=cur_color; see optional feature.
  - COLOR: no write. cur_color increments next cycle, wrapping 2^COLOR_W-1 -> 1 (0 skipped). Stay IDLE.
  - SLEEP/LIGHT/STOP: accepted and discarded, stay IDLE.
- WR1:
  - fb_we=1 with the latched address and data, pen_ready=0.
  - Latency is fixed: handshake at edge T gives fb_we high for the cycle after T.
  - Next state is WR2 if the wide condition holds, else IDLE.
- WR2:
  - fb_we=1, fb_addr = previous addr+1, same data, pen_ready=0. Then IDLE.
- Boundary cases:
  - A pen hit is never lost while pen_ready=1.
  - Back-to-back hits give at most one write per 2 cycles (IDLE/WR1 alternation).
  - state==RST during WR1/WR2: the current write completes, then IDLE handles RST.
  - Async reset mid-sweep aborts immediately; the sweep restarts from address 0.

Optional Feature:
CANVAS_WIDE_PEN_EN
- Defined: in WRITE mode the stroke is 2 pixels wide. WR1 is followed by WR2 (pixel col+1) when latched col < COLS-1. At col = COLS-1 the stroke is a single write; no wrap to the next row.
- Undefined: WR2 is never entered. WRITE behaves exactly like DRAW.

Test Plan:
- Release reset with state=RST -> fb_we high 64 consecutive cycles, addr 0..63, data 0; rst_ok=1 from the next cycle; pen_ready=0 throughout; state->SLEEP then rst_ok=0, pen_ready=1.
- state=DRAW, cur_color=1, pen (2,3) handshake at edge T -> cycle after T: fb_we=1, fb_addr=19, fb_wdata=1, pen_ready=0; next cycle pen_ready=1.
- state=COLOR, three hits -> cur_color 1->2->3->1; fb_we stays 0.
- CANVAS_WIDE_PEN_EN, state=WRITE: pen (1,6) -> writes addr 14 then 15 on consecutive cycles; pen (1,7) -> single write addr 15. Macro undefined: pen (1,6) -> only addr 14.
- state=ERASE: pen (0,0) -> fb_addr=0, fb_wdata=0. Pen row=7 col=7 -> addr 63. Force out-of-range row 8 (wider bench driver or ROWS=6 with row 6) -> accepted, no fb_we.
- Assert rst asynchronously mid-sweep at addr 30 -> fb_we=0, rst_ok=0 immediately. After release, sweep restarts at addr 0 and completes to 63.

Source files
------------

// File: rtl/canvas_ctrl.sv
// canvas_ctrl: frame-buffer write controller for the light-pen screen.
// Clears the whole canvas each time the mode FSM enters RST and reports
// completion on rst_ok. After that it turns accepted pen hits into pixel
// writes according to the current mode. All outputs are registered.
//
// Optional build macro: CANVAS_WIDE_PEN_EN
//   defined   - WRITE mode draws a 2-pixel stroke (col and col+1, same row)
//   undefined - WRITE mode behaves exactly like DRAW
//
// The mode codes come from the shared state header. The fallback values
// below apply only when that header has not been included first.

`ifndef RST
`define RST   3'd0
`endif
`ifndef SLEEP
`define SLEEP 3'd1
`endif
`ifndef LIGHT
`define LIGHT 3'd2
`endif
`ifndef DRAW
`define DRAW  3'd3
`endif
`ifndef WRITE
`define WRITE 3'd4
`endif
`ifndef ERASE
`define ERASE 3'd5
`endif
`ifndef COLOR
`define COLOR 3'd6
`endif
`ifndef STOP
`define STOP  3'd7
`endif

module canvas_ctrl #(
    parameter int ROWS    = 8,
    parameter int COLS    = 8,
    parameter int ADDR_W  = 6,
    parameter int COLOR_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         state,
    input  logic               pen_valid,
    input  logic [2:0]         pen_row,
    input  logic [2:0]         pen_col,
    output logic               pen_ready,
    output logic               fb_we,
    output logic [ADDR_W-1:0]  fb_addr,
    output logic [COLOR_W-1:0] fb_wdata,
    output logic [COLOR_W-1:0] cur_color,
    output logic               rst_ok,
    output logic               busy
);

    typedef enum logic [2:0] {
        CLEAR,
        DONE,
        IDLE,
        WR1,
        WR2
    } fsm_t;

    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(ROWS * COLS - 1);
    localparam logic [COLOR_W-1:0] COLOR_MAX = {COLOR_W{1'b1}};
    localparam logic [COLOR_W-1:0] COLOR_ONE = COLOR_W'(1);

    fsm_t               fsm_q, fsm_d;
    logic [ADDR_W-1:0]  cnt_q, cnt_d;
    logic               we_d, rst_ok_d, ready_d, busy_d;
    logic [ADDR_W-1:0]  addr_d;
    logic [COLOR_W-1:0] wdata_d, color_d;
    logic               hit, hit_in_range;
    logic [ADDR_W-1:0]  hit_addr;
`ifdef CANVAS_WIDE_PEN_EN
    logic               wide_q, wide_d;
`endif

    assign hit          = pen_valid && pen_ready;
    assign hit_in_range = (int'(pen_row) < ROWS) && (int'(pen_col) < COLS);
    assign hit_addr     = ADDR_W'(pen_row) * ADDR_W'(COLS) + ADDR_W'(pen_col);

    // State, sweep counter and all registered outputs.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q     <= CLEAR;
            cnt_q     <= '0;
            fb_we     <= 1'b0;
            fb_addr   <= '0;
            fb_wdata  <= '0;
            rst_ok    <= 1'b0;
            pen_ready <= 1'b0;
            cur_color <= COLOR_ONE;
            busy      <= 1'b1;
`ifdef CANVAS_WIDE_PEN_EN
            wide_q    <= 1'b0;
`endif
        end else begin
            fsm_q     <= fsm_d;
            cnt_q     <= cnt_d;
            fb_we     <= we_d;
            fb_addr   <= addr_d;
            fb_wdata  <= wdata_d;
            rst_ok    <= rst_ok_d;
            pen_ready <= ready_d;
            cur_color <= color_d;
            busy      <= busy_d;
`ifdef CANVAS_WIDE_PEN_EN
            wide_q    <= wide_d;
`endif
        end
    end

    // Next state and next values of the registered outputs.
    // NOTE: every signal gets a default before the case statement, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        fsm_d    = fsm_q;
        cnt_d    = cnt_q;
        we_d     = 1'b0;
        addr_d   = fb_addr;
        wdata_d  = fb_wdata;
        color_d  = cur_color;
        rst_ok_d = 1'b0;
        ready_d  = 1'b0;
`ifdef CANVAS_WIDE_PEN_EN
        wide_d   = wide_q;
`endif

        case (fsm_q)
            CLEAR: begin
                we_d    = 1'b1;
                addr_d  = cnt_q;
                wdata_d = '0;
                if (cnt_q == LAST_ADDR) begin
                    fsm_d = DONE;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end

            DONE: begin
                // Leaving DONE drops rst_ok and raises pen_ready together.
                if (state == `RST) begin
                    rst_ok_d = 1'b1;
                end else begin
                    fsm_d   = IDLE;
                    ready_d = 1'b1;
                end
            end

            IDLE: begin
                if (state == `RST) begin
                    // RST wins over a simultaneous hit; the hit is ignored.
                    fsm_d   = CLEAR;
                    cnt_d   = '0;
                    color_d = COLOR_ONE;
                end else begin
                    ready_d = 1'b1;
                    if (hit && hit_in_range) begin
                        case (state)
                            `DRAW, `WRITE, `ERASE: begin
                                fsm_d   = WR1;
                                we_d    = 1'b1;
                                ready_d = 1'b0;
                                addr_d  = hit_addr;
                                wdata_d = (state == `ERASE) ? '0 : cur_color;
`ifdef CANVAS_WIDE_PEN_EN
                                // Second pixel only if it stays on the same row.
                                wide_d  = (state == `WRITE) &&
                                          (int'(pen_col) < COLS - 1);
`endif
                            end
                            `COLOR: begin
                                color_d = (cur_color == COLOR_MAX) ? COLOR_ONE
                                                                   : cur_color + COLOR_ONE;
                            end
                            default: ;
                        endcase
                    end
                end
            end

            WR1: begin
`ifdef CANVAS_WIDE_PEN_EN
                if (wide_q) begin
                    fsm_d  = WR2;
                    we_d   = 1'b1;
                    addr_d = fb_addr + ADDR_W'(1);
                end else begin
                    fsm_d   = IDLE;
                    ready_d = (state != `RST);
                end
`else
                fsm_d   = IDLE;
                ready_d = (state != `RST);
`endif
            end

            WR2: begin
                fsm_d   = IDLE;
                ready_d = (state != `RST);
            end

            default: begin
                fsm_d = CLEAR;
                cnt_d = '0;
            end
        endcase

        busy_d = (fsm_d == CLEAR) || (fsm_d == WR1) || (fsm_d == WR2);
    end

endmodule

// File: tb/tb_canvas_ctrl.sv
// tb_canvas_ctrl: directed, table-driven bench for canvas_ctrl.
// Main instance uses the default 8x8 canvas; a second 6x8 instance lets a
// 3-bit row value be out of range. Honours CANVAS_WIDE_PEN_EN when defined.

`ifndef RST
`define RST   3'd0
`endif
`ifndef SLEEP
`define SLEEP 3'd1
`endif
`ifndef LIGHT
`define LIGHT 3'd2
`endif
`ifndef DRAW
`define DRAW  3'd3
`endif
`ifndef WRITE
`define WRITE 3'd4
`endif
`ifndef ERASE
`define ERASE 3'd5
`endif
`ifndef COLOR
`define COLOR 3'd6
`endif
`ifndef STOP
`define STOP  3'd7
`endif

module tb_canvas_ctrl;

`ifdef CANVAS_WIDE_PEN_EN
    localparam logic WIDE = 1'b1;
`else
    localparam logic WIDE = 1'b0;
`endif

    logic       clk, rst;
    logic [2:0] state, pen_row, pen_col;
    logic       pen_valid;
    logic       pen_ready, fb_we, rst_ok, busy;
    logic [5:0] fb_addr;
    logic [1:0] fb_wdata, cur_color;

    logic [2:0] s_state, s_row, s_col;
    logic       s_valid, s_pen_ready, s_fb_we, s_rst_ok, s_busy;
    logic [5:0] s_fb_addr;
    logic [1:0] s_fb_wdata, s_cur_color;

    int n_cmp = 0;
    int n_bad = 0;

    canvas_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .state     (state),
        .pen_valid (pen_valid),
        .pen_row   (pen_row),
        .pen_col   (pen_col),
        .pen_ready (pen_ready),
        .fb_we     (fb_we),
        .fb_addr   (fb_addr),
        .fb_wdata  (fb_wdata),
        .cur_color (cur_color),
        .rst_ok    (rst_ok),
        .busy      (busy)
    );

    canvas_ctrl #(.ROWS(6), .COLS(8), .ADDR_W(6), .COLOR_W(2)) dut_s (
        .clk       (clk),
        .rst       (rst),
        .state     (s_state),
        .pen_valid (s_valid),
        .pen_row   (s_row),
        .pen_col   (s_col),
        .pen_ready (s_pen_ready),
        .fb_we     (s_fb_we),
        .fb_addr   (s_fb_addr),
        .fb_wdata  (s_fb_wdata),
        .cur_color (s_cur_color),
        .rst_ok    (s_rst_ok),
        .busy      (s_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] mode;
        logic [2:0] row;
        logic [2:0] col;
        logic       we1;
        logic [5:0] addr1;
        logic [1:0] data1;
        logic       we2;
        logic [5:0] addr2;
        logic [1:0] color;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Walk a full 64-address clear sweep, one check per cycle.
    task automatic check_sweep(input string name);
        for (int i = 0; i < 64; i++) begin
            tick();
            check(name, {fb_we, fb_addr, fb_wdata, pen_ready, rst_ok},
                  {1'b1, 6'(i), 2'b00, 1'b0, 1'b0});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the summary in time");
        $fatal(1, "timeout");
    end

    initial begin
        //                mode    row   col   we1   addr1  d1    we2   addr2  color
        vecs[0]  = '{`DRAW,  3'd2, 3'd3, 1'b1, 6'd19, 2'd1, 1'b0, 6'd0,  2'd1};
        vecs[1]  = '{`COLOR, 3'd0, 3'd0, 1'b0, 6'd0,  2'd0, 1'b0, 6'd0,  2'd2};
        vecs[2]  = '{`COLOR, 3'd1, 3'd1, 1'b0, 6'd0,  2'd0, 1'b0, 6'd0,  2'd3};
        vecs[3]  = '{`COLOR, 3'd2, 3'd2, 1'b0, 6'd0,  2'd0, 1'b0, 6'd0,  2'd1};
        vecs[4]  = '{`COLOR, 3'd3, 3'd3, 1'b0, 6'd0,  2'd0, 1'b0, 6'd0,  2'd2};
        vecs[5]  = '{`DRAW,  3'd7, 3'd7, 1'b1, 6'd63, 2'd2, 1'b0, 6'd0,  2'd2};
        vecs[6]  = '{`ERASE, 3'd0, 3'd0, 1'b1, 6'd0,  2'd0, 1'b0, 6'd0,  2'd2};
        vecs[7]  = '{`ERASE, 3'd7, 3'd7, 1'b1, 6'd63, 2'd0, 1'b0, 6'd0,  2'd2};
        vecs[8]  = '{`WRITE, 3'd1, 3'd6, 1'b1, 6'd14, 2'd2, WIDE, 6'd15, 2'd2};
        vecs[9]  = '{`WRITE, 3'd1, 3'd7, 1'b1, 6'd15, 2'd2, 1'b0, 6'd0,  2'd2};
        vecs[10] = '{`SLEEP, 3'd4, 3'd4, 1'b0, 6'd0,  2'd0, 1'b0, 6'd0,  2'd2};
        vecs[11] = '{`LIGHT, 3'd4, 3'd4, 1'b0, 6'd0,  2'd0, 1'b0, 6'd0,  2'd2};
        vecs[12] = '{`STOP,  3'd1, 3'd1, 1'b0, 6'd0,  2'd0, 1'b0, 6'd0,  2'd2};
        vecs[13] = '{`DRAW,  3'd0, 3'd7, 1'b1, 6'd7,  2'd2, 1'b0, 6'd0,  2'd2};

        rst       = 1'b1;
        state     = `RST;
        pen_valid = 1'b0;
        pen_row   = '0;
        pen_col   = '0;
        s_state   = `RST;
        s_valid   = 1'b0;
        s_row     = '0;
        s_col     = '0;

        // Reset values.
        #3;
        check("reset_we", fb_we, 1'b0);
        check("reset_addr", fb_addr, 6'd0);
        check("reset_wdata", fb_wdata, 2'd0);
        check("reset_rst_ok", rst_ok, 1'b0);
        check("reset_ready", pen_ready, 1'b0);
        check("reset_color", cur_color, 2'd1);

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Initial clear sweep, then DONE holds rst_ok while state==RST.
        check_sweep("sweep1");
        tick();
        check("done_rst_ok", {fb_we, rst_ok, pen_ready}, {1'b0, 1'b1, 1'b0});
        tick();
        check("done_hold", {fb_we, rst_ok, pen_ready}, {1'b0, 1'b1, 1'b0});
        state = `SLEEP;
        tick();
        check("done_exit", {fb_we, rst_ok, pen_ready}, {1'b0, 1'b0, 1'b1});

        // Table: one hit per record; mode changes right after the handshake.
        foreach (vecs[k]) begin
            state     = vecs[k].mode;
            pen_row   = vecs[k].row;
            pen_col   = vecs[k].col;
            pen_valid = 1'b1;
            tick();
            pen_valid = 1'b0;
            state     = `SLEEP;
            check($sformatf("v%0d_we1", k), fb_we, vecs[k].we1);
            if (vecs[k].we1) begin
                check($sformatf("v%0d_wr1", k), {fb_addr, fb_wdata, pen_ready},
                      {vecs[k].addr1, vecs[k].data1, 1'b0});
            end
            tick();
            check($sformatf("v%0d_we2", k), fb_we, vecs[k].we2);
            if (vecs[k].we2) begin
                check($sformatf("v%0d_wr2", k), {fb_addr, fb_wdata, pen_ready},
                      {vecs[k].addr2, vecs[k].data1, 1'b0});
                tick();
            end
            check($sformatf("v%0d_idle", k), {fb_we, pen_ready, busy}, {1'b0, 1'b1, 1'b0});
            check($sformatf("v%0d_color", k), cur_color, vecs[k].color);
        end

        // Back-to-back hits with pen_valid held: write, gap, write.
        state     = `DRAW;
        pen_row   = 3'd3;
        pen_col   = 3'd0;
        pen_valid = 1'b1;
        tick();
        check("b2b_first", {fb_we, fb_addr, fb_wdata}, {1'b1, 6'd24, 2'd2});
        tick();
        check("b2b_gap", {fb_we, pen_ready}, {1'b0, 1'b1});
        tick();
        check("b2b_second", {fb_we, fb_addr}, {1'b1, 6'd24});
        pen_valid = 1'b0;
        tick();
        check("b2b_idle", {fb_we, pen_ready}, {1'b0, 1'b1});

        // RST arriving during WR1: the write completes, then a new clear.
        state     = `DRAW;
        pen_row   = 3'd5;
        pen_col   = 3'd5;
        pen_valid = 1'b1;
        tick();
        pen_valid = 1'b0;
        state     = `RST;
        check("rstwr_write", {fb_we, fb_addr, fb_wdata}, {1'b1, 6'd45, 2'd2});
        tick();
        check("rstwr_idle", {fb_we, pen_ready}, {1'b0, 1'b0});
        tick();
        check("rstwr_clear_entry", {fb_we, busy, cur_color}, {1'b0, 1'b1, 2'd1});
        tick();
        check("rstwr_first", {fb_we, fb_addr, fb_wdata}, {1'b1, 6'd0, 2'd0});
        repeat (30) tick();
        check("midsweep_addr", {fb_we, fb_addr}, {1'b1, 6'd30});

        // Async reset mid-sweep takes effect before the next edge.
        #2;
        rst = 1'b1;
        #1;
        check("async_abort", {fb_we, rst_ok, fb_addr}, {1'b0, 1'b0, 6'd0});
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_sweep("sweep2");
        tick();
        check("sweep2_done", {fb_we, rst_ok}, {1'b0, 1'b1});
        state = `SLEEP;
        tick();
        check("sweep2_exit", {rst_ok, pen_ready}, {1'b0, 1'b1});

        // 6-row instance: row 6 is accepted and dropped, row 5 writes.
        check("small_rst_ok", s_rst_ok, 1'b1);
        s_state = `ERASE;
        tick();
        check("small_ready", s_pen_ready, 1'b1);
        s_row   = 3'd6;
        s_col   = 3'd0;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        check("oor_accept", {s_fb_we, s_pen_ready}, {1'b0, 1'b1});
        tick();
        check("oor_nowrite", s_fb_we, 1'b0);
        s_row   = 3'd5;
        s_col   = 3'd7;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        check("small_last", {s_fb_we, s_fb_addr, s_fb_wdata}, {1'b1, 6'd47, 2'd0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
